// File: rtl/rvp_ctrl_pkg.sv
// rtl/rvp_ctrl_pkg.sv - shared state encoding and parameter defaults for the run controller
package rvp_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HOLD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DUMP  = 3'd4,
        ST_DONE  = 3'd5
    } run_state_e;

    localparam int unsigned DEF_RESET_CYCLES   = 20;
    localparam int unsigned DEF_MAX_RUN_CYCLES = 200;
    localparam int unsigned DEF_DRAIN_CYCLES   = 4;

    // A phase length of zero still has to occupy one cycle so the FSM stays well-formed.
    function automatic int unsigned eff_cycles(input int unsigned n);
        return (n == 0) ? 1 : n;
    endfunction

endpackage

// File: rtl/rvp_sat_counter.sv
// rtl/rvp_sat_counter.sv - up-counter with synchronous clear that sticks at all-ones
module rvp_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    // Clear has priority; increment stops once every bit is set.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/rvp_run_ctrl.sv
// rtl/rvp_run_ctrl.sv - sequences core reset, run, drain and dump for one program execution
module rvp_run_ctrl
    import rvp_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES   = DEF_RESET_CYCLES,
    parameter int unsigned MAX_RUN_CYCLES = DEF_MAX_RUN_CYCLES,
    parameter int unsigned DRAIN_CYCLES   = DEF_DRAIN_CYCLES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] end_pc,
    input  logic [31:0] pc_out,
    input  logic        wb_e,
    input  logic [4:0]  wb_a,
    output logic        core_reset,
    output logic        core_dump,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [31:0] run_cycles,
    output logic [31:0] wb_count
);

    // HOLD and DRAIN share one down-counter; it is loaded with length-1 and the phase ends at zero.
    localparam logic [31:0] HOLD_LOAD  = 32'(eff_cycles(RESET_CYCLES) - 1);
    localparam logic [31:0] DRAIN_LOAD = 32'(eff_cycles(DRAIN_CYCLES) - 1);
    localparam logic [31:0] RUN_LAST   = 32'(eff_cycles(MAX_RUN_CYCLES) - 1);

    run_state_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] end_pc_q, end_pc_d;
    logic        timeout_q, timeout_d;
    logic        start_acc;
    logic        core_reset_q, core_dump_q, busy_q, done_q;
    logic        run_en, wb_en;

    // Next-state logic; the end address is checked before the timeout so it wins a tie.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        end_pc_d  = end_pc_q;
        timeout_d = timeout_q;
        start_acc = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_HOLD;
                    cnt_d     = HOLD_LOAD;
                    end_pc_d  = end_pc;
                    timeout_d = 1'b0;
                    start_acc = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) state_d = ST_RUN;
                else             cnt_d   = cnt_q - 32'd1;
            end
            ST_RUN: begin
                if (pc_out >= end_pc_q) begin
                    state_d   = ST_DRAIN;
                    cnt_d     = DRAIN_LOAD;
                    timeout_d = 1'b0;
                end else if (run_cycles >= RUN_LAST) begin
                    state_d   = ST_DRAIN;
                    cnt_d     = DRAIN_LOAD;
                    timeout_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) state_d = ST_DUMP;
                else             cnt_d   = cnt_q - 32'd1;
            end
            ST_DUMP: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, phase counter and captured run parameters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            end_pc_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            end_pc_q  <= end_pc_d;
            timeout_q <= timeout_d;
        end
    end

    // Outputs are decoded from the next state so they are flop outputs aligned with state_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_reset_q <= 1'b1;
            core_dump_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            core_reset_q <= (state_d == ST_IDLE) || (state_d == ST_HOLD);
            core_dump_q  <= (state_d == ST_DUMP);
            busy_q       <= (state_d == ST_HOLD) || (state_d == ST_RUN) ||
                            (state_d == ST_DRAIN) || (state_d == ST_DUMP);
            done_q       <= (state_d == ST_DONE);
        end
    end

    assign run_en = (state_q == ST_RUN);
    assign wb_en  = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && wb_e && (wb_a != 5'd0);

    rvp_sat_counter #(.W(32)) u_run_cnt (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .clr_i   (start_acc),
        .en_i    (run_en),
        .count_o (run_cycles)
    );

    rvp_sat_counter #(.W(32)) u_wb_cnt (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .clr_i   (start_acc),
        .en_i    (wb_en),
        .count_o (wb_count)
    );

    assign core_reset = core_reset_q;
    assign core_dump  = core_dump_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign timeout    = timeout_q;

endmodule

// File: doc/rvp_run_ctrl.md
RVP_RUN_CTRL -- requirements
Module: rvp_run_ctrl

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 20, number of cycles the core is held in reset after start.
REQ-002 SHALL have parameter MAX_RUN_CYCLES, default 200, timeout limit in RUN cycles.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 4, cycles allowed for in-flight instructions to retire before dump.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  run request, sampled in IDLE or DONE only.
REQ-007 SHALL have port end_pc  input  32  stop address, captured on accepted start.
REQ-008 SHALL have port pc_out  input  32  current PC from riscv_pipeline.
REQ-009 SHALL have port wb_e  input  1  pipeline writeback enable.
REQ-010 SHALL have port wb_a  input  5  pipeline writeback register address.
REQ-011 SHALL have port core_reset  output  1  active-high reset to riscv_pipeline.
REQ-012 SHALL have port core_dump  output  1  dump strobe to riscv_pipeline.
REQ-013 SHALL have port busy  output  1  high in HOLD, RUN, DRAIN, DUMP.
REQ-014 SHALL have port done  output  1  high in DONE.
REQ-015 SHALL have port timeout  output  1  run ended on MAX_RUN_CYCLES, valid while done.
REQ-016 SHALL have port run_cycles  output  32  RUN cycles elapsed.
REQ-017 SHALL have port wb_count  output  32  retired writebacks to non-zero registers.

Function
REQ-018 SHALL implement states IDLE, HOLD, RUN, DRAIN, DUMP, DONE; all outputs registered (Moore).
REQ-019 IDLE: core_reset=1, core_dump=0; start=1 -> HOLD next cycle, end_pc latched, run_cycles, wb_count, timeout cleared.
REQ-020 HOLD: core_reset=1 for exactly RESET_CYCLES cycles, then -> RUN.
REQ-021 RUN: core_reset=0; run_cycles increments by 1 each RUN cycle.
REQ-022 RUN exit: pc_out >= latched end_pc (unsigned) -> DRAIN with timeout=0.
REQ-023 RUN exit: run_cycles reaching MAX_RUN_CYCLES-1 without end condition -> DRAIN with timeout=1.
REQ-024 Both exit conditions in the same cycle -> end_pc wins, timeout=0.
REQ-025 DRAIN: core_reset=0 for exactly DRAIN_CYCLES cycles, then -> DUMP.
REQ-026 DUMP: core_dump=1 for exactly one cycle, core_reset=0, then -> DONE.
REQ-027 DONE: done=1, core_reset=0, counters and timeout frozen; start=1 -> HOLD with same clearing as REQ-019.
REQ-028 start SHALL be ignored in HOLD, RUN, DRAIN, DUMP.
REQ-029 wb_count SHALL increment when wb_e=1 and wb_a!=0 during RUN or DRAIN only.
REQ-030 Counters SHALL saturate at 32'hFFFF_FFFF, never wrap.
REQ-031 Parameter RESET_CYCLES or DRAIN_CYCLES of 0 SHALL be treated as 1.

Reset
REQ-032 reset_n=0 SHALL immediately force IDLE, core_reset=1, core_dump=0, busy=0, done=0, timeout=0, run_cycles=0, wb_count=0, latched end_pc=0.
REQ-033 reset_n assertion mid-run (any state) SHALL abort with no dump pulse; reset deassertion SHALL resume in IDLE.

Structure
REQ-034 State enum and parameter defaults SHALL live in shared package rvp_ctrl_pkg.
REQ-035 A single sub-module rvp_sat_counter (32-bit, clear, enable, saturate) SHALL be instantiated for run_cycles and wb_count.
REQ-036 HOLD and DRAIN SHALL share one down-counter loaded on state entry.

Verification
REQ-037 start with end_pc=150, pc_out ramps by 4 per RUN cycle from 0 -> core_reset low after 20 HOLD cycles, DRAIN at pc_out=152, core_dump high 1 cycle 4 cycles later, done=1, timeout=0.
REQ-038 end_pc=150, pc_out held at 8 -> DRAIN after 200 RUN cycles, run_cycles=200, timeout=1, single core_dump pulse.
REQ-039 pc_out crosses end_pc on the timeout cycle -> timeout=0.
REQ-040 wb_e pulses 10 times with wb_a=5 and 3 times with wb_a=0 in RUN, 2 with wb_a=7 in DRAIN -> wb_count=12.
REQ-041 reset_n low during DRAIN -> outputs at reset values same cycle, no core_dump, start after release runs normally.
REQ-042 start held high in RUN -> no effect; start in DONE -> counters cleared, HOLD re-entered next cycle.
